// File: rtl/fifo_read_ctrl_pkg.sv
// Shared FIFO definitions: storage geometry, read-side state type and pointer arithmetic.
package fifo_pkg;

  localparam int FIFO_DATA_W = 4;
  localparam int FIFO_ADDR_W = 8;
  localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } rd_state_e;

  // Occupancy between two wrap-bit pointers; modulo arithmetic keeps it correct across wrap.
  function automatic logic [FIFO_PTR_W-1:0] ptr_diff(input logic [FIFO_PTR_W-1:0] wptr,
                                                     input logic [FIFO_PTR_W-1:0] rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Output stream of the FIFO read side: registered word with valid/ready handshake.
interface fifo_read_ctrl_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the FIFO: owns rPtr, derives empty, presents a registered stream.
// Optional occupancy outputs (rd_level, almost_empty) are built when FIFO_RD_LEVEL_EN is defined.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int PTR_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PTR_W-1:0]  wPtr,
  output logic [PTR_W-1:0]  rPtr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              empty,
  fifo_read_ctrl_if.master  rd
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [PTR_W:0]    rd_level,
  output logic              almost_empty
`endif
);

  rd_state_e         state, state_nxt;
  logic              fetch;
  logic [DATA_W-1:0] dout_p0;

  assign empty         = (wPtr == rPtr);
  assign rd.dout       = dout_p0;
  assign rd.dout_valid = (state == VALID);

  // Flush suppresses the fetch so the read pointer can be reloaded from wPtr.
  always_comb begin
    fetch     = 1'b0;
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      fetch = !empty && ((state == IDLE) || rd.dout_ready);
      case (state)
        IDLE:    if (fetch) state_nxt = VALID;
        VALID:   if (rd.dout_ready) state_nxt = fetch ? VALID : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p0: fetched word and read pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rPtr    <= '0;
      dout_p0 <= '0;
    end else if (flush) begin
      rPtr    <= wPtr;
    end else if (fetch) begin
      rPtr    <= rPtr + PTR_W'(1);
      dout_p0 <= mem_rdata;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  // The held output word counts toward the level even though empty ignores it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_level <= '0;
    end else begin
      rd_level <= {1'b0, ptr_diff(wPtr, rPtr)} + {{PTR_W{1'b0}}, rd.dout_valid};
    end
  end

  assign almost_empty = (rd_level <= (PTR_W+1)'(2));
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl against a queue-based model of the read stream.
module tb_fifo_read_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] wPtr;
  logic [8:0] rPtr;
  logic [3:0] mem_rdata;
  logic       flush;
  logic       empty;
  logic [3:0] mem [256];
`ifdef FIFO_RD_LEVEL_EN
  logic [9:0] rd_level;
  logic       almost_empty;
`endif

  fifo_read_ctrl_if #(.DATA_W(4)) rd_if ();

  fifo_read_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wPtr      (wPtr),
    .rPtr      (rPtr),
    .mem_rdata (mem_rdata),
    .flush     (flush),
    .empty     (empty),
    .rd        (rd_if)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level     (rd_level),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[rPtr[7:0]];

  int errs = 0;
  int checks = 0;

  // Model: words written but not yet fetched, plus the word presented at the output.
  logic [3:0] mq [$];
  bit         m_held;
  logic [3:0] m_dout;
  logic [8:0] m_rptr;
  logic [9:0] m_level;

  task automatic model_clear();
    mq.delete();
    m_held  = 0;
    m_dout  = 4'h0;
    m_rptr  = 9'h0;
    m_level = 10'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wPtr = 9'h0;
    flush = 1'b0;
    rd_if.dout_ready = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, let the write side land its word after the edge.
  task automatic cycle(input bit wr, input logic [3:0] wd, input bit rdy, input bit fl);
    logic [9:0] lvl_n;
    rd_if.dout_ready = rdy;
    flush = fl;
    lvl_n = {1'b0, wPtr - m_rptr} + {9'h0, m_held};
    if (fl) begin
      mq.delete();
      m_held = 0;
      m_rptr = wPtr;
    end else begin
      if (m_held && rdy) m_held = 0;
      if (!m_held && mq.size() > 0) begin
        m_dout = mq.pop_front();
        m_held = 1;
        m_rptr = m_rptr + 9'h1;
      end
    end
    if (wr) mq.push_back(wd);
    @(posedge clk);
    #1;
    if (wr) begin
      mem[wPtr[7:0]] = wd;
      wPtr = wPtr + 9'h1;
    end
    m_level = lvl_n;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wPtr = 9'h0;
    flush = 1'b0;
    rd_if.dout_ready = 1'b0;
    model_clear();
    #3;
    checks += 4;
    if (rPtr !== 9'h0) begin errs++; $display("FAIL reset_rptr got %h exp 000", rPtr); end
    if (rd_if.dout !== 4'h0) begin errs++; $display("FAIL reset_dout got %h exp 0", rd_if.dout); end
    if (rd_if.dout_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", rd_if.dout_valid); end
    if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b exp 1", empty); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_first_word();
    do_reset();
    cycle(1, 4'hA, 0, 0);
    checks += 2;
    if (rd_if.dout_valid !== 1'b0) begin errs++; $display("FAIL first_latency valid got %b exp 0", rd_if.dout_valid); end
    if (empty !== 1'b0) begin errs++; $display("FAIL first_empty1 got %b exp 0", empty); end
    cycle(0, 4'h0, 0, 0);
    checks += 4;
    if (rd_if.dout !== 4'hA) begin errs++; $display("FAIL first_dout got %h exp a", rd_if.dout); end
    if (rd_if.dout_valid !== 1'b1) begin errs++; $display("FAIL first_valid got %b exp 1", rd_if.dout_valid); end
    if (rPtr !== 9'h1) begin errs++; $display("FAIL first_rptr got %h exp 001", rPtr); end
    if (empty !== 1'b1) begin errs++; $display("FAIL first_empty2 got %b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(i < 8, 4'(i + 1), 1, 0);
      checks += 3;
      if (rd_if.dout !== m_dout) begin errs++; $display("FAIL b2b_dout[%0d] got %h exp %h", i, rd_if.dout, m_dout); end
      if (rd_if.dout_valid !== m_held) begin errs++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, rd_if.dout_valid, m_held); end
      if (rPtr !== m_rptr) begin errs++; $display("FAIL b2b_rptr[%0d] got %h exp %h", i, rPtr, m_rptr); end
    end
    checks += 2;
    if (rd_if.dout_valid !== 1'b0) begin errs++; $display("FAIL b2b_drop got %b exp 0", rd_if.dout_valid); end
    if (rPtr !== 9'h8) begin errs++; $display("FAIL b2b_final_rptr got %h exp 008", rPtr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 4'(4'hC + i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'h0, 0, 0);
      checks += 3;
      if (rd_if.dout !== 4'hC) begin errs++; $display("FAIL bp_hold_dout[%0d] got %h exp c", i, rd_if.dout); end
      if (rPtr !== 9'h1) begin errs++; $display("FAIL bp_hold_rptr[%0d] got %h exp 001", i, rPtr); end
      if (rd_if.dout_valid !== 1'b1) begin errs++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", i, rd_if.dout_valid); end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 4'h0, 1, 0);
      checks += 2;
      if (rd_if.dout !== 4'(4'hD + i)) begin errs++; $display("FAIL bp_order[%0d] got %h exp %h", i, rd_if.dout, 4'(4'hD + i)); end
      if (rPtr !== m_rptr) begin errs++; $display("FAIL bp_rptr[%0d] got %h exp %h", i, rPtr, m_rptr); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    wPtr = 9'h0FF;
    cycle(0, 4'h0, 1, 1);
    cycle(1, 4'h5, 1, 0);
    checks += 1;
    if (rPtr !== 9'h0FF) begin errs++; $display("FAIL wrap_start got %h exp 0ff", rPtr); end
    cycle(1, 4'h6, 1, 0);
    checks += 2;
    if (rPtr !== 9'h100) begin errs++; $display("FAIL wrap_rptr1 got %h exp 100", rPtr); end
    if (rd_if.dout !== 4'h5) begin errs++; $display("FAIL wrap_dout1 got %h exp 5", rd_if.dout); end
    cycle(0, 4'h0, 1, 0);
    checks += 3;
    if (rPtr !== 9'h101) begin errs++; $display("FAIL wrap_rptr2 got %h exp 101", rPtr); end
    if (rd_if.dout !== 4'h6) begin errs++; $display("FAIL wrap_dout2 got %h exp 6", rd_if.dout); end
    if (rd_if.dout_valid !== 1'b1) begin errs++; $display("FAIL wrap_valid got %b exp 1", rd_if.dout_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 4'h1, 0, 0);
    cycle(1, 4'h2, 0, 0);
    cycle(1, 4'h3, 1, 0);
    cycle(1, 4'h4, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 4'(5 + i), 0, 0);
    checks += 3;
    if (rPtr !== 9'h3) begin errs++; $display("FAIL flush_pre_rptr got %h exp 003", rPtr); end
    if (wPtr !== 9'hA) begin errs++; $display("FAIL flush_pre_wptr got %h exp 00a", wPtr); end
    if (rd_if.dout_valid !== 1'b1) begin errs++; $display("FAIL flush_pre_valid got %b exp 1", rd_if.dout_valid); end
    cycle(0, 4'h0, 1, 1);
    checks += 3;
    if (rPtr !== 9'hA) begin errs++; $display("FAIL flush_rptr got %h exp 00a", rPtr); end
    if (rd_if.dout_valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %b exp 0", rd_if.dout_valid); end
    if (empty !== 1'b1) begin errs++; $display("FAIL flush_empty got %b exp 1", empty); end
    // A write landing with the flush must survive it.
    cycle(1, 4'h9, 1, 1);
    cycle(0, 4'h0, 0, 0);
    checks += 2;
    if (rd_if.dout !== 4'h9) begin errs++; $display("FAIL flush_keep_dout got %h exp 9", rd_if.dout); end
    if (rd_if.dout_valid !== 1'b1) begin errs++; $display("FAIL flush_keep_valid got %b exp 1", rd_if.dout_valid); end
  endtask

`ifdef FIFO_RD_LEVEL_EN
  task automatic test_level();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 4'(i + 3), 0, 0);
    cycle(0, 4'h0, 0, 0);
    checks += 2;
    if (rd_level !== 10'd4) begin errs++; $display("FAIL level4 got %0d exp 4", rd_level); end
    if (almost_empty !== 1'b0) begin errs++; $display("FAIL level4_ae got %b exp 0", almost_empty); end
    cycle(0, 4'h0, 1, 0);
    cycle(0, 4'h0, 1, 0);
    cycle(0, 4'h0, 0, 0);
    checks += 2;
    if (rd_level !== 10'd2) begin errs++; $display("FAIL level2 got %0d exp 2", rd_level); end
    if (almost_empty !== 1'b1) begin errs++; $display("FAIL level2_ae got %b exp 1", almost_empty); end
  endtask
`endif

  task automatic test_random();
    bit wr, rdy, fl;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      wr  = ($urandom_range(0, 99) < 60) && (9'(wPtr - m_rptr) < 9'd256);
      rdy = ($urandom_range(0, 99) < 55);
      fl  = ($urandom_range(0, 49) == 0);
      cycle(wr, 4'($urandom), rdy, fl);
      checks += 4;
      if (rd_if.dout !== m_dout) begin errs++; $display("FAIL rand_dout[%0d] got %h exp %h", i, rd_if.dout, m_dout); end
      if (rd_if.dout_valid !== m_held) begin errs++; $display("FAIL rand_valid[%0d] got %b exp %b", i, rd_if.dout_valid, m_held); end
      if (rPtr !== m_rptr) begin errs++; $display("FAIL rand_rptr[%0d] got %h exp %h", i, rPtr, m_rptr); end
      if (empty !== (wPtr == m_rptr)) begin errs++; $display("FAIL rand_empty[%0d] got %b exp %b", i, empty, wPtr == m_rptr); end
`ifdef FIFO_RD_LEVEL_EN
      checks += 2;
      if (rd_level !== m_level) begin errs++; $display("FAIL rand_level[%0d] got %0d exp %0d", i, rd_level, m_level); end
      if (almost_empty !== (m_level <= 10'd2)) begin errs++; $display("FAIL rand_ae[%0d] got %b exp %b", i, almost_empty, m_level <= 10'd2); end
`endif
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 4'(i + 7), 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checks += 3;
    if (rPtr !== 9'h0) begin errs++; $display("FAIL arst_rptr got %h exp 000", rPtr); end
    if (rd_if.dout !== 4'h0) begin errs++; $display("FAIL arst_dout got %h exp 0", rd_if.dout); end
    if (rd_if.dout_valid !== 1'b0) begin errs++; $display("FAIL arst_valid got %b exp 0", rd_if.dout_valid); end
`ifdef FIFO_RD_LEVEL_EN
    checks += 1;
    if (rd_level !== 10'd0) begin errs++; $display("FAIL arst_level got %0d exp 0", rd_level); end
`endif
    wPtr = 9'h0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'h0;
    test_reset();
    test_first_word();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_flush();
`ifdef FIFO_RD_LEVEL_EN
    test_level();
`endif
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
